seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: WIDTH, 4, operand/result width in bits (legal range 2..32).
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  asynchronous active-high reset.
REQ-005 Port: in_valid  input  1  op, a and b carry a valid request.
REQ-006 Port: in_ready  output  1  block accepts a request this cycle.
REQ-007 Port: op  input  3  operation select.
REQ-008 Port: a  input  WIDTH  operand A.
REQ-009 Port: b  input  WIDTH  operand B.
REQ-010 Port: out_valid  output  1  result and flags are valid.
REQ-011 Port: out_ready  input  1  consumer takes the result this cycle.
REQ-012 Port: result  output  WIDTH  registered result.
REQ-013 Port: Z, C, V, S  output  1 each  zero, carry/borrow, signed overflow and sign flags.

Function
REQ-014 Op encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL1, 110 SHR1 (logical), 111 MUL (unsigned, low WIDTH bits).
REQ-015 Handshake: a request is accepted on a rising edge with in_valid=1 and in_ready=1; op, a and b are sampled only at acceptance.
REQ-016 FSM states: IDLE, MUL, HOLD; in_ready=1 only in IDLE; out_valid=1 only in HOLD.
REQ-017 IDLE, accepting a non-MUL op: go to HOLD; result and flags are registered on that edge (latency 1 cycle).
REQ-018 IDLE, accepting MUL: go to MUL; load multiplicand, multiplier and a 2*WIDTH accumulator; clear the cycle counter.
REQ-019 MUL: one shift-add step per cycle for exactly WIDTH cycles, then go to HOLD (out_valid asserts WIDTH+1 cycles after acceptance).
REQ-020 HOLD: result and flags stay stable while out_ready=0; out_ready=1 returns the FSM to IDLE on that edge (no accept in the same cycle).
REQ-021 Z = (result == 0) for every op; S = result[WIDTH-1] for every op.
REQ-022 ADD: C = carry out of bit WIDTH-1; V = signed overflow (operand signs equal, result sign differs).
REQ-023 SUB: result = a - b mod 2^WIDTH; C = 1 iff a < b unsigned (borrow); V = signed overflow (operand signs differ, result sign differs from a).
REQ-024 AND, OR, XOR: C = 0, V = 0.
REQ-025 SHL1: C = a[WIDTH-1], V = 0. SHR1: C = a[0], V = 0, MSB filled with 0.
REQ-026 MUL: C = V = 1 iff the upper WIDTH bits of the full product are nonzero.
REQ-027 in_valid=1 outside IDLE has no effect; inputs are ignored.

Reset
REQ-028 rst=1 forces IDLE immediately; result, Z, C, V, S, out_valid and the MUL counter/accumulator go to 0; in_ready=1.
REQ-029 rst mid-MUL or in HOLD discards the operation; no out_valid follows after reset deasserts.

Structure
REQ-030 Package alu_pkg holds the op enum (3-bit) and the FSM state enum; seq_alu imports it.
REQ-031 Sub-module alu_core (combinational, parametrised by WIDTH) computes the single-cycle results and flags; the FSM and multiplier stay in seq_alu.

Verification (WIDTH=4)
REQ-032 ADD a=0111 b=0001 -> next cycle out_valid=1, result=1000, Z=0 C=0 V=1 S=1.
REQ-033 ADD a=1111 b=0001 -> result=0000, Z=1 C=1 V=0 S=0; SUB a=0011 b=0101 -> result=1110, C=1 V=0 S=1.
REQ-034 MUL a=0101 b=0011 -> out_valid exactly 5 cycles after acceptance, result=1111, C=0 V=0; MUL 0110*0110 -> result=0100, C=1 V=1.
REQ-035 Backpressure: out_ready=0 for 3 cycles in HOLD -> result/flags unchanged, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-036 rst asserted mid-MUL (cycle 2) -> outputs 0 within the same cycle, in_ready=1 after release, no stray out_valid.
REQ-037 SHL1 a=1001 -> result=0010, C=1; SHR1 a=1001 -> result=0100, C=1, S=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: operation encoding and controller states.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_SHL1 = 3'b101,
        OP_SHR1 = 3'b110,
        OP_MUL  = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle datapath: result and Z/C/V/S for every op except MUL.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             z,
    output logic             c,
    output logic             v,
    output logic             s
);

    logic [WIDTH:0] ext;

    always_comb begin
        ext    = '0;
        result = '0;
        c      = 1'b0;
        v      = 1'b0;
        case (op)
            OP_ADD: begin
                ext    = {1'b0, a} + {1'b0, b};
                result = ext[WIDTH-1:0];
                c      = ext[WIDTH];
                v      = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // Extended subtraction: the extra top bit is the borrow (a < b unsigned).
                ext    = {1'b0, a} - {1'b0, b};
                result = ext[WIDTH-1:0];
                c      = ext[WIDTH];
                v      = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SHL1: begin
                result = {a[WIDTH-2:0], 1'b0};
                c      = a[WIDTH-1];
            end
            OP_SHR1: begin
                result = {1'b0, a[WIDTH-1:1]};
                c      = a[0];
            end
            default: result = '0;
        endcase
        z = (result == '0);
        s = result[WIDTH-1];
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshake; single-cycle ops via alu_core, MUL by shift-add.
//
// state   | meaning
// IDLE    | in_ready=1, waiting for a request
// MUL     | one shift-add step per cycle, WIDTH steps
// HOLD    | out_valid=1, result held until out_ready
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             Z,
    output logic             C,
    output logic             V,
    output logic             S
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t             state;
    op_t                op_in;
    logic [WIDTH-1:0]   core_res;
    logic               core_z, core_c, core_v, core_s;
    logic [2*WIDTH-1:0] mcand, acc, acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mul_res;
    logic               mul_hi;

    assign op_in = op_t'(op);

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op     (op_in),
        .a      (a),
        .b      (b),
        .result (core_res),
        .z      (core_z),
        .c      (core_c),
        .v      (core_v),
        .s      (core_s)
    );

    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign mul_res  = acc_next[WIDTH-1:0];
    assign mul_hi   = |acc_next[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            Z         <= 1'b0;
            C         <= 1'b0;
            V         <= 1'b0;
            S         <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (op_in == OP_MUL) begin
                            state  <= ST_MUL;
                            mcand  <= {{WIDTH{1'b0}}, a};
                            mplier <= b;
                            acc    <= '0;
                            cnt    <= '0;
                        end else begin
                            state     <= ST_HOLD;
                            out_valid <= 1'b1;
                            result    <= core_res;
                            Z         <= core_z;
                            C         <= core_c;
                            V         <= core_v;
                            S         <= core_s;
                        end
                    end
                end
                ST_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    // Last step: publish the product directly from the adder output.
                    if (cnt == CW'(WIDTH - 1)) begin
                        state     <= ST_HOLD;
                        out_valid <= 1'b1;
                        result    <= mul_res;
                        Z         <= (mul_res == '0);
                        C         <= mul_hi;
                        V         <= mul_hi;
                        S         <= mul_res[WIDTH-1];
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=4): directed vectors, random ops against a reference model.
module tb_seq_alu;

    localparam int W = 4;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         Z, C, V, S;

    int checks   = 0;
    int failures = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .Z         (Z),
        .C         (C),
        .V         (V),
        .S         (S)
    );

    always #5 clk = ~clk;

    function automatic int to_signed(input int x);
        return (x >= (1 << (W - 1))) ? x - (1 << W) : x;
    endfunction

    // Reference model from plain integer arithmetic.
    function automatic void model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic z, output logic c,
                                  output logic v, output logic s);
        int ua, ub, full, sres;
        ua = int'(x);
        ub = int'(y);
        c = 1'b0;
        v = 1'b0;
        full = 0;
        case (o)
            3'd0: begin
                full = ua + ub;
                c = (full > MASK);
                sres = to_signed(ua) + to_signed(ub);
                v = (sres > (1 << (W - 1)) - 1) || (sres < -(1 << (W - 1)));
            end
            3'd1: begin
                full = ua - ub;
                c = (ua < ub);
                sres = to_signed(ua) - to_signed(ub);
                v = (sres > (1 << (W - 1)) - 1) || (sres < -(1 << (W - 1)));
            end
            3'd2: full = ua & ub;
            3'd3: full = ua | ub;
            3'd4: full = ua ^ ub;
            3'd5: begin
                full = ua * 2;
                c = (ua >= (1 << (W - 1)));
            end
            3'd6: begin
                full = ua / 2;
                c = (ua % 2) == 1;
            end
            default: begin
                full = ua * ub;
                c = (full > MASK);
                v = c;
            end
        endcase
        r = W'(full & MASK);
        z = ((full & MASK) == 0);
        s = ((full & MASK) >= (1 << (W - 1)));
    endfunction

    // Drives one request, measures latency, holds for `hold` cycles with junk on the inputs, releases.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int hold, output logic [W-1:0] r, output logic [3:0] f,
                          output int lat, output bit stable, output bit idle_ok);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = (n >= 100) ? -1 : 1;
        while (lat > 0 && !out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        r = result;
        f = {Z, C, V, S};
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; op = 3'($urandom); a = W'($urandom); b = W'($urandom);
            @(posedge clk); #1;
            if (result !== r || {Z, C, V, S} !== f || in_ready !== 1'b0 || out_valid !== 1'b1)
                stable = 1'b0;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        idle_ok = (in_ready === 1'b1) && (out_valid === 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, result, Z, C, V, S} !== {1'b1, 1'b0, {W{1'b0}}, 4'b0000}) begin
            failures++;
            $display("FAIL reset: in_ready=%b out_valid=%b result=%b ZCVS=%b, required 1 0 0000 0000",
                     in_ready, out_valid, result, {Z, C, V, S});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    typedef struct {
        logic [2:0]   o;
        logic [W-1:0] x, y, r;
        logic [3:0]   f;
        int           lat;
    } vec_t;

    task automatic test_directed();
        vec_t vecs[7];
        logic [W-1:0] r; logic [3:0] f; int lat; bit st, id;
        vecs[0] = '{3'd0, 4'b0111, 4'b0001, 4'b1000, 4'b0011, 1};
        vecs[1] = '{3'd0, 4'b1111, 4'b0001, 4'b0000, 4'b1100, 1};
        vecs[2] = '{3'd1, 4'b0011, 4'b0101, 4'b1110, 4'b0101, 1};
        vecs[3] = '{3'd7, 4'b0101, 4'b0011, 4'b1111, 4'b0001, 5};
        vecs[4] = '{3'd7, 4'b0110, 4'b0110, 4'b0100, 4'b0110, 5};
        vecs[5] = '{3'd5, 4'b1001, 4'b0000, 4'b0010, 4'b0100, 1};
        vecs[6] = '{3'd6, 4'b1001, 4'b0000, 4'b0100, 4'b0100, 1};
        foreach (vecs[i]) begin
            run_op(vecs[i].o, vecs[i].x, vecs[i].y, 0, r, f, lat, st, id);
            checks++;
            if (r !== vecs[i].r || f !== vecs[i].f || lat != vecs[i].lat || !id) begin
                failures++;
                $display("FAIL directed[%0d]: result=%b ZCVS=%b lat=%0d idle=%0d, required result=%b ZCVS=%b lat=%0d idle=1",
                         i, r, f, lat, id, vecs[i].r, vecs[i].f, vecs[i].lat);
            end
        end
    endtask

    task automatic test_random(input int n, input int max_hold, input string name);
        logic [2:0] o; logic [W-1:0] x, y, r, er; logic [3:0] f; logic ez, ec, ev, es;
        int lat, elat; bit st, id;
        for (int i = 0; i < n; i++) begin
            o = 3'($urandom); x = W'($urandom); y = W'($urandom);
            model(o, x, y, er, ez, ec, ev, es);
            elat = (o == 3'd7) ? W + 1 : 1;
            run_op(o, x, y, $urandom_range(max_hold, 0), r, f, lat, st, id);
            checks++;
            if (r !== er || f !== {ez, ec, ev, es} || lat != elat || !st || !id) begin
                failures++;
                $display("FAIL %s[%0d] op=%0d a=%b b=%b: result=%b ZCVS=%b lat=%0d stable=%0d idle=%0d, required result=%b ZCVS=%b lat=%0d 1 1",
                         name, i, o, x, y, r, f, lat, st, id, er, {ez, ec, ev, es}, elat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] r0; logic [3:0] f0; int n;
        op = 3'd0; a = 4'b0011; b = 4'b0100; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        r0 = result; f0 = {Z, C, V, S};
        checks++;
        if (out_valid !== 1'b1 || r0 !== 4'b0111 || f0 !== 4'b0000) begin
            failures++;
            $display("FAIL bp_first: out_valid=%b result=%b ZCVS=%b, required 1 0111 0000", out_valid, r0, f0);
        end
        for (int i = 0; i < 3; i++) begin
            op = 3'd4; a = 4'b1010; b = 4'b0101; in_valid = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (result !== 4'b0111 || {Z, C, V, S} !== 4'b0000 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold[%0d]: result=%b ZCVS=%b in_ready=%b out_valid=%b, required 0111 0000 0 1",
                         i, result, {Z, C, V, S}, in_ready, out_valid);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_mul();
        logic [W-1:0] r; logic [3:0] f; int lat; bit st, id; bit stray;
        run_op(3'd0, 4'b0111, 4'b0001, 0, r, f, lat, st, id);
        op = 3'd7; a = 4'b1111; b = 4'b1111; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, result, Z, C, V, S} !== {1'b1, 1'b0, {W{1'b0}}, 4'b0000}) begin
            failures++;
            $display("FAIL rst_mid_mul: in_ready=%b out_valid=%b result=%b ZCVS=%b, required 1 0 0000 0000",
                     in_ready, out_valid, result, {Z, C, V, S});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            failures++;
            $display("FAIL rst_no_stray: out_valid/in_ready changed after reset, required out_valid=0 in_ready=1");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random(60, 3, "random");
        test_random(20, 0, "back_to_back");
        test_reset_mid_mul();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
